obb_juicer_seq: RTL and testbench

- Sequential, parametrised successor to the combinational OBB processor.
- Accepts one OBB per valid/ready transaction and looks up sin/cos from a quarter-wave LUT.
- Computes the u/v basis, the half extents and the four vertices using one shared signed multiplier over four cycles, then holds the result until downstream accepts.
- Sits between the OBB register file and the SAT/collision stage.

---
 rtl/obb_juicer_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_obb_juicer_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obb_juicer_seq.sv
// obb_juicer_seq: sequential oriented-bounding-box processor.
// Takes one OBB per valid/ready handshake and looks up sin/cos from a
// quarter-wave table. It then builds the u/v basis, the half extents and the
// four corner vertices, using one shared signed multiplier over four cycles.
// The result is held until the downstream stage accepts it.
module obb_juicer_seq #(
  parameter int POS_W     = 16,
  parameter int FRAC_W    = 0,
  parameter int ANGLE_W   = 8,
  parameter int TRIG_FRAC = 7,
  parameter int TAG_W     = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [POS_W-1:0]       in_pos_x,
  input  logic [POS_W-1:0]       in_pos_y,
  input  logic [POS_W-1:0]       in_width,
  input  logic [POS_W-1:0]       in_height,
  input  logic [ANGLE_W-1:0]     in_angle,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TRIG_FRAC+1:0]   out_u_x,
  output logic [TRIG_FRAC+1:0]   out_u_y,
  output logic [TRIG_FRAC+1:0]   out_v_x,
  output logic [TRIG_FRAC+1:0]   out_v_y,
  output logic [POS_W-1:0]       out_half_w,
  output logic [POS_W-1:0]       out_half_h,
  output logic [8*POS_W-1:0]     out_pts,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);

  // Trig width: sign bit, one integer bit (to hold exactly 1.0) and the fraction.
  localparam int TW    = TRIG_FRAC + 2;
  // Entries per quarter turn; the quadrant index takes the top two angle bits.
  localparam int IDX_W = ANGLE_W - 2;
  localparam int Q     = 1 << IDX_W;
  localparam int ONE   = 1 << TRIG_FRAC;
  // The full product width: a zero-extended half extent times a signed trig value.
  localparam int PW    = POS_W + 1 + TW;
  localparam real HALF_PI = 1.5707963267948966;

  // Fractional position bits pass through the arithmetic untouched. They only
  // have to leave room for an integer part.
  if (ANGLE_W < 4 || FRAC_W < 0 || FRAC_W >= POS_W) begin : g_bad_params
    $error("obb_juicer_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, LUT, MUL0, MUL1, MUL2, MUL3, SUM, DONE
  } state_t;

  state_t state_reg, state_next;

  // Captured transaction
  logic [POS_W-1:0]   pos_x_reg, pos_y_reg;
  logic [POS_W-1:0]   width_reg, height_reg;
  logic [ANGLE_W-1:0] angle_reg;
  logic [TAG_W-1:0]   tag_reg;

  // Trig values and half extents (LUT stage), then products (MUL stages)
  logic signed [TW-1:0] c_reg, s_reg;
  logic [POS_W-1:0]     hw_reg, hh_reg;
  logic [POS_W-1:0]     prod_a_reg, prod_b_reg, prod_c_reg, prod_d_reg;

  // Result registers that drive the ports
  logic [TW-1:0]        out_u_x_reg, out_u_y_reg, out_v_x_reg, out_v_y_reg;
  logic [POS_W-1:0]     out_half_w_reg, out_half_h_reg;
  logic [8*POS_W-1:0]   out_pts_reg;
  logic [TAG_W-1:0]     out_tag_reg;

  // Quarter-wave sine ROM. It is read only in the LUT state, and the read
  // lands directly in c_reg and s_reg.
  logic signed [TW-1:0] lut_rom [Q];

  for (genvar gi = 0; gi < Q; gi++) begin : g_lut
    localparam int LUT_VAL =
      $rtoi($sin(HALF_PI * real'(gi) / real'(Q)) * real'(ONE) + 0.5);
    assign lut_rom[gi] = TW'(LUT_VAL);
  end

  // Two lookups share the ROM. Lane 0 gives sin(angle). Lane 1 gives
  // cos(angle), taken as sin(angle + quarter turn).
  for (genvar gi = 0; gi < 2; gi++) begin : g_trig
    logic [ANGLE_W-1:0]   ang;
    logic [1:0]           quad;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     mirror_idx;
    logic signed [TW-1:0] mag;
    logic signed [TW-1:0] val;

    assign ang = angle_reg + ANGLE_W'(gi * Q);

    // Fold the angle into the first quadrant, then restore the sign.
    always_comb begin
      quad       = ang[ANGLE_W-1 -: 2];
      idx        = ang[IDX_W-1:0];
      // Q - idx modulo Q; only used when idx != 0, where the result is Q-idx
      mirror_idx = IDX_W'(0) - idx;
      mag        = lut_rom[idx];
      if (quad[0]) begin
        mag = (idx == '0) ? TW'(ONE) : lut_rom[mirror_idx];
      end
      val = quad[1] ? -mag : mag;
    end
  end

  logic signed [TW-1:0] sin_val, cos_val;
  assign sin_val = g_trig[0].val;
  assign cos_val = g_trig[1].val;

  // Shared multiplier. The operand pair depends on the MUL state. The product
  // is floor-shifted by the trig fraction and then truncated to POS_W.
  logic signed [POS_W:0]  mul_a;
  logic signed [TW-1:0]   mul_b;
  logic signed [PW-1:0]   prod_full;
  logic [POS_W-1:0]       prod_trunc;

  // Select operands for the shared multiplier and form the scaled product.
  always_comb begin
    mul_a = {1'b0, hw_reg};
    mul_b = c_reg;
    case (state_reg)
      MUL1: mul_b = s_reg;
      MUL2: begin
        mul_a = {1'b0, hh_reg};
        mul_b = s_reg;
      end
      MUL3: begin
        mul_a = {1'b0, hh_reg};
        mul_b = c_reg;
      end
      default: ;
    endcase
    prod_full  = PW'(mul_a) * PW'(mul_b);
    prod_trunc = POS_W'(prod_full >>> TRIG_FRAC);
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and the handshake/status outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = LUT;
      end
      LUT:  state_next = MUL0;
      MUL0: state_next = MUL1;
      MUL1: state_next = MUL2;
      MUL2: state_next = MUL3;
      MUL3: state_next = SUM;
      SUM:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, trig/half-extent, products, then the result on SUM->DONE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x_reg      <= '0;
      pos_y_reg      <= '0;
      width_reg      <= '0;
      height_reg     <= '0;
      angle_reg      <= '0;
      tag_reg        <= '0;
      c_reg          <= '0;
      s_reg          <= '0;
      hw_reg         <= '0;
      hh_reg         <= '0;
      prod_a_reg     <= '0;
      prod_b_reg     <= '0;
      prod_c_reg     <= '0;
      prod_d_reg     <= '0;
      out_u_x_reg    <= '0;
      out_u_y_reg    <= '0;
      out_v_x_reg    <= '0;
      out_v_y_reg    <= '0;
      out_half_w_reg <= '0;
      out_half_h_reg <= '0;
      out_pts_reg    <= '0;
      out_tag_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            pos_x_reg  <= in_pos_x;
            pos_y_reg  <= in_pos_y;
            width_reg  <= in_width;
            height_reg <= in_height;
            angle_reg  <= in_angle;
            tag_reg    <= in_tag;
          end
        end
        LUT: begin
          c_reg  <= cos_val;
          s_reg  <= sin_val;
          hw_reg <= width_reg >> 1;
          hh_reg <= height_reg >> 1;
        end
        MUL0: prod_a_reg <= prod_trunc;
        MUL1: prod_b_reg <= prod_trunc;
        MUL2: prod_c_reg <= prod_trunc;
        MUL3: prod_d_reg <= prod_trunc;
        SUM: begin
          out_u_x_reg    <= c_reg;
          out_u_y_reg    <= s_reg;
          out_v_x_reg    <= -s_reg;
          out_v_y_reg    <= c_reg;
          out_half_w_reg <= hw_reg;
          out_half_h_reg <= hh_reg;
          out_tag_reg    <= tag_reg;
          // Corners wrap modulo 2^POS_W; p0 sits in the least significant slot
          out_pts_reg <= {
            pos_y_reg + prod_b_reg - prod_d_reg,
            pos_x_reg + prod_a_reg + prod_c_reg,
            pos_y_reg + prod_b_reg + prod_d_reg,
            pos_x_reg + prod_a_reg - prod_c_reg,
            pos_y_reg - prod_b_reg + prod_d_reg,
            pos_x_reg - prod_a_reg - prod_c_reg,
            pos_y_reg - prod_b_reg - prod_d_reg,
            pos_x_reg - prod_a_reg + prod_c_reg
          };
        end
        default: ;
      endcase
    end
  end

  assign out_u_x    = out_u_x_reg;
  assign out_u_y    = out_u_y_reg;
  assign out_v_x    = out_v_x_reg;
  assign out_v_y    = out_v_y_reg;
  assign out_half_w = out_half_w_reg;
  assign out_half_h = out_half_h_reg;
  assign out_pts    = out_pts_reg;
  assign out_tag    = out_tag_reg;

endmodule

// File: tb/tb_obb_juicer_seq.sv
// Testbench for obb_juicer_seq. A behavioural model predicts every output on
// every cycle. Directed cases pin the model with hand-computed literals, and a
// randomized phase follows the directed cases.
module tb_obb_juicer_seq;
  localparam int POS_W     = 16;
  localparam int ANGLE_W   = 8;
  localparam int TRIG_FRAC = 7;
  localparam int TAG_W     = 4;
  localparam int TW        = TRIG_FRAC + 2;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [POS_W-1:0]     in_pos_x = '0, in_pos_y = '0, in_width = '0, in_height = '0;
  logic [ANGLE_W-1:0]   in_angle = '0;
  logic [TAG_W-1:0]     in_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [TW-1:0]        out_u_x, out_u_y, out_v_x, out_v_y;
  logic [POS_W-1:0]     out_half_w, out_half_h;
  logic [8*POS_W-1:0]   out_pts;
  logic [TAG_W-1:0]     out_tag;
  logic                 busy;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  always #5 Clk = ~Clk;

  obb_juicer_seq #(
    .POS_W(POS_W), .FRAC_W(0), .ANGLE_W(ANGLE_W), .TRIG_FRAC(TRIG_FRAC), .TAG_W(TAG_W)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pos_x(in_pos_x), .in_pos_y(in_pos_y),
    .in_width(in_width), .in_height(in_height),
    .in_angle(in_angle), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_u_x(out_u_x), .out_u_y(out_u_y), .out_v_x(out_v_x), .out_v_y(out_v_y),
    .out_half_w(out_half_w), .out_half_h(out_half_h),
    .out_pts(out_pts), .out_tag(out_tag), .busy(busy)
  );

  typedef struct packed {
    logic [TW-1:0]      ux, uy, vx, vy;
    logic [POS_W-1:0]   hw, hh;
    logic [8*POS_W-1:0] pts;
    logic [TAG_W-1:0]   tag;
  } res_t;

  // ---------------- behavioural model ----------------
  int sin_tbl [64];

  // Sine of a binary angle (0..255), rounded to 7 fractional bits, by quadrant.
  function automatic int sine_of(int a);
    int q, idx, m;
    q   = a / 64;
    idx = a % 64;
    if (q % 2 == 0) m = sin_tbl[idx];
    else            m = (idx == 0) ? 128 : sin_tbl[64 - idx];
    return (q >= 2) ? -m : m;
  endfunction

  function automatic res_t model_result(logic [15:0] px_i, logic [15:0] py_i,
                                        logic [15:0] w, logic [15:0] h,
                                        logic [7:0] ang, logic [3:0] tag);
    res_t r;
    int c, s, hw, hh, a, b, cc, d, px, py;
    c  = sine_of((int'(ang) + 64) % 256);
    s  = sine_of(int'(ang));
    hw = int'(w) / 2;
    hh = int'(h) / 2;
    a  = (hw * c) >>> 7;
    b  = (hw * s) >>> 7;
    cc = (hh * s) >>> 7;
    d  = (hh * c) >>> 7;
    px = int'(signed'(px_i));
    py = int'(signed'(py_i));
    r.ux  = 9'(c);
    r.uy  = 9'(s);
    r.vx  = 9'(-s);
    r.vy  = 9'(c);
    r.hw  = 16'(hw);
    r.hh  = 16'(hh);
    r.tag = tag;
    r.pts[0*16 +: 16] = 16'(px - a + cc);
    r.pts[1*16 +: 16] = 16'(py - b - d);
    r.pts[2*16 +: 16] = 16'(px - a - cc);
    r.pts[3*16 +: 16] = 16'(py - b + d);
    r.pts[4*16 +: 16] = 16'(px + a - cc);
    r.pts[5*16 +: 16] = 16'(py + b + d);
    r.pts[6*16 +: 16] = 16'(px + a + cc);
    r.pts[7*16 +: 16] = 16'(py + b - d);
    return r;
  endfunction

  // Transaction-level timing: a result appears 6 clock edges after its
  // accepting edge. It is then held until out_ready, and a new OBB is
  // accepted only when nothing is in flight.
  int   countdown = 0;
  bit   exp_valid = 1'b0;
  res_t exp_res   = '0;
  res_t pend      = '0;

  always @(posedge Clk) begin
    if (Reset) begin
      countdown <= 0;
      exp_valid <= 1'b0;
      exp_res   <= '0;
      pend      <= '0;
    end else if (exp_valid) begin
      if (out_ready) exp_valid <= 1'b0;
    end else if (countdown > 0) begin
      countdown <= countdown - 1;
      if (countdown == 1) begin
        exp_valid <= 1'b1;
        exp_res   <= pend;
      end
    end else if (in_valid) begin
      pend      <= model_result(in_pos_x, in_pos_y, in_width, in_height, in_angle, in_tag);
      countdown <= 6;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on every cycle.
  always @(negedge Clk) begin
    if (check_en) begin
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, (!exp_valid && countdown == 0));
      chk("busy", busy, (exp_valid || countdown != 0));
      chk("u_x", out_u_x, exp_res.ux);
      chk("u_y", out_u_y, exp_res.uy);
      chk("v_x", out_v_x, exp_res.vx);
      chk("v_y", out_v_y, exp_res.vy);
      chk("half_w", out_half_w, exp_res.hw);
      chk("half_h", out_half_h, exp_res.hh);
      chk("pts", out_pts, exp_res.pts);
      chk("tag", out_tag, exp_res.tag);
    end
  end

  // ---------------- directed helpers ----------------
  // Present an OBB from a negedge and hold it until the accepting edge.
  task automatic send(input logic [15:0] px, input logic [15:0] py, input logic [15:0] w,
                      input logic [15:0] h, input logic [7:0] ang, input logic [3:0] tag);
    int guard;
    in_valid = 1'b1; in_pos_x = px; in_pos_y = py;
    in_width = w; in_height = h; in_angle = ang; in_tag = tag;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    in_angle = 8'($urandom);
    in_tag   = 4'($urandom);
  endtask

  // Counts clock edges from the accepting edge (inclusive) until out_valid.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge Clk);
      edges++;
      @(negedge Clk);
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL wait_valid_timeout: out_valid stayed 0, expected 1");
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_pts(input string n, input int p0x, input int p0y, input int p1x,
                         input int p1y, input int p2x, input int p2y, input int p3x,
                         input int p3y);
    logic [127:0] want;
    want = {16'(p3y), 16'(p3x), 16'(p2y), 16'(p2x), 16'(p1y), 16'(p1x), 16'(p0y), 16'(p0x)};
    chk(n, out_pts, want);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int edges;
    logic [127:0] snap_pts;
    logic [3:0]   snap_tag;

    for (int i = 0; i < 64; i++)
      sin_tbl[i] = $rtoi($floor($sin(1.5707963267948966 * real'(i) / 64.0) * 128.0 + 0.5));

    // Reset state
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check_en = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pts", out_pts, '0);

    // Angle 0
    send(16'd100, 16'd50, 16'd20, 16'd10, 8'd0, 4'd3);
    wait_valid(edges);
    chk("a0_latency_edges", edges, 7);
    chk("a0_u_x", out_u_x, 9'd128);
    chk("a0_u_y", out_u_y, 9'd0);
    chk("a0_v_x", out_v_x, 9'd0);
    chk("a0_v_y", out_v_y, 9'd128);
    chk("a0_hw", out_half_w, 16'd10);
    chk("a0_hh", out_half_h, 16'd5);
    chk("a0_tag", out_tag, 4'd3);
    chk_pts("a0_pts", 90, 45, 90, 55, 110, 55, 110, 45);
    handshake();

    // Angle 64 (90 degrees)
    send(16'd100, 16'd50, 16'd20, 16'd10, 8'd64, 4'd4);
    wait_valid(edges);
    chk("a64_u_x", out_u_x, 9'd0);
    chk("a64_u_y", out_u_y, 9'd128);
    chk("a64_v_x", out_v_x, 9'h180);
    chk("a64_v_y", out_v_y, 9'd0);
    chk_pts("a64_pts", 105, 40, 95, 40, 95, 60, 105, 60);
    handshake();

    // Angle 128 and 192
    send(16'd100, 16'd50, 16'd20, 16'd10, 8'd128, 4'd5);
    wait_valid(edges);
    chk("a128_u_x", out_u_x, 9'h180);
    chk("a128_u_y", out_u_y, 9'd0);
    chk("a128_p0", out_pts[31:0], {16'd55, 16'd110});
    handshake();
    send(16'd100, 16'd50, 16'd20, 16'd10, 8'd192, 4'd6);
    wait_valid(edges);
    chk("a192_u_x", out_u_x, 9'd0);
    chk("a192_u_y", out_u_y, 9'h180);
    handshake();

    // Backpressure: hold the result and offer a second OBB meanwhile
    send(16'd200, 16'd300, 16'd40, 16'd8, 8'd32, 4'd7);
    wait_valid(edges);
    snap_pts = out_pts;
    snap_tag = out_tag;
    in_valid = 1'b1; in_pos_x = 16'd10; in_pos_y = 16'd20;
    in_width = 16'd6; in_height = 16'd4; in_angle = 8'd0; in_tag = 4'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_pts_stable", out_pts, snap_pts);
      chk("bp_tag_stable", out_tag, snap_tag);
    end
    handshake();
    chk("bp_idle_ready", in_ready, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    wait_valid(edges);
    chk("bp_second_tag", out_tag, 4'd9);
    chk_pts("bp_second_pts", 7, 18, 7, 22, 13, 22, 13, 18);
    handshake();

    // Reset while in MUL2
    send(16'd1000, 16'd2000, 16'd100, 16'd60, 8'd20, 4'd11);
    @(posedge Clk);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_pts", out_pts, '0);
    chk("mrst_u_x", out_u_x, '0);
    send(16'd100, 16'd50, 16'd20, 16'd10, 8'd0, 4'd12);
    wait_valid(edges);
    chk("mrst_after_tag", out_tag, 4'd12);
    chk_pts("mrst_after_pts", 90, 45, 90, 55, 110, 55, 110, 45);
    handshake();

    // Wrap and odd width
    send(16'd32767, 16'd0, 16'd20, 16'd10, 8'd0, 4'd1);
    wait_valid(edges);
    chk("wrap_p2x", out_pts[79:64], 16'h8009);
    handshake();
    send(16'd32767, 16'd0, 16'd21, 16'd10, 8'd0, 4'd2);
    wait_valid(edges);
    chk("odd_hw", out_half_w, 16'd10);
    chk("odd_p2x", out_pts[79:64], 16'h8009);
    handshake();

    // Zero size: every vertex equals the centre
    send(16'd1234, 16'hFF00, 16'd0, 16'd0, 8'd37, 4'd8);
    wait_valid(edges);
    chk_pts("zero_pts", 1234, -256, 1234, -256, 1234, -256, 1234, -256);
    handshake();

    // Randomized traffic with backpressure and occasional reset
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge Clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_pos_x  = 16'($urandom);
      in_pos_y  = 16'($urandom);
      in_width  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      in_height = 16'($urandom);
      in_angle  = 8'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      Reset     = ($urandom_range(0, 199) == 0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
